// File: rtl/rr_arb8_if.sv
// Request/grant bundle between the requesting blocks and the rr_arb8 arbiter.
interface rr_arb8_if;
  logic [7:0] req;
  logic [2:0] gidx;
  logic [7:0] gnt;
  logic       valid;

  modport master (output req, input gidx, input gnt, input valid);
  modport slave  (input req, output gidx, output gnt, output valid);
endinterface

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with a hold limit; drives the decoder select
// index and the matching one-hot grant for a single shared resource.
module rr_arb8 #(
  parameter int unsigned MAXHOLD = 15
) (
  input logic   clk,
  input logic   rst,
  rr_arb8_if.slave bus
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned HW = 4;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [HW-1:0]   hcnt;
  logic [IW-1:0]   gidx_q;
  logic [N-1:0]    gnt_q;
  logic            valid_q;

  logic [2*N-1:0]  dbl_c;
  logic [N-1:0]    rot_c;
  logic [IW-1:0]   off_c;
  logic [IW-1:0]   win_c;

  // Rotate requests so bit 0 is the current priority start, then take the lowest set bit.
  always_comb begin
    dbl_c = {bus.req, bus.req};
    rot_c = dbl_c[ptr +: N];
    off_c = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_c[i]) off_c = IW'(i);
    end
    win_c = ptr + off_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      hcnt    <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state   <= BUSY;
            gidx_q  <= win_c;
            gnt_q   <= N'(1) << win_c;
            valid_q <= 1'b1;
            hcnt    <= HW'(1);
          end
        end
        BUSY: begin
          // Voluntary or forced release both hand priority to the next index.
          if (!bus.req[gidx_q] || (hcnt == HW'(MAXHOLD))) begin
            state   <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            ptr     <= gidx_q + IW'(1);
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          gnt_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gidx  = gidx_q;
  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8: three instances with hold limits 15, 3 and 2.
module tb_rr_arb8;

  logic clk;
  logic rst15, rst3, rst2;
  int   total;
  int   passed;

  rr_arb8_if b15 ();
  rr_arb8_if b3 ();
  rr_arb8_if b2 ();

  rr_arb8 #(.MAXHOLD(15)) u15 (.clk(clk), .rst(rst15), .bus(b15));
  rr_arb8 #(.MAXHOLD(3))  u3  (.clk(clk), .rst(rst3),  .bus(b3));
  rr_arb8 #(.MAXHOLD(2))  u2  (.clk(clk), .rst(rst2),  .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [2:0] ag, input logic [7:0] an, input logic av,
                     input logic [2:0] eg, input logic [7:0] en, input logic ev);
    total++;
    assert ({ag, an, av} === {eg, en, ev}) passed++;
    else $error("FAIL %s: got gidx=%0d gnt=%b valid=%b, expected gidx=%0d gnt=%b valid=%b",
                tag, ag, an, av, eg, en, ev);
  endtask

  task automatic c15(input string tag, input logic [2:0] eg, input logic [7:0] en, input logic ev);
    chk(tag, b15.gidx, b15.gnt, b15.valid, eg, en, ev);
  endtask

  task automatic c3(input string tag, input logic [2:0] eg, input logic [7:0] en, input logic ev);
    chk(tag, b3.gidx, b3.gnt, b3.valid, eg, en, ev);
  endtask

  task automatic c2(input string tag, input logic [2:0] eg, input logic [7:0] en, input logic ev);
    chk(tag, b2.gidx, b2.gnt, b2.valid, eg, en, ev);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst15  = 1'b1;
    rst3   = 1'b1;
    rst2   = 1'b1;
    b15.req = 8'hFF;
    b3.req  = 8'hFF;
    b2.req  = 8'h00;

    // Reset held two cycles with every requester active
    tick(); c15("reset_c1", 3'd0, 8'h00, 1'b0);
    tick(); c15("reset_c2", 3'd0, 8'h00, 1'b0);
    rst15 = 1'b0;
    tick(); c15("first_grant_idx0", 3'd0, 8'h01, 1'b1);
    b15.req = 8'h00;
    tick(); c15("release_idx0", 3'd0, 8'h00, 1'b0);

    // Single requester 2 held five cycles (pointer now 1)
    b15.req = 8'b0000_0100;
    for (int i = 0; i < 5; i++) begin
      tick(); c15($sformatf("single_hold_%0d", i), 3'd2, 8'h04, 1'b1);
    end
    b15.req = 8'h00;
    tick(); c15("single_drop", 3'd2, 8'h00, 1'b0);

    // Move pointer to 5 via a grant to requester 4
    b15.req = 8'b0001_0000;
    tick(); c15("grant_idx4", 3'd4, 8'h10, 1'b1);
    b15.req = 8'h00;
    tick(); c15("release_idx4", 3'd4, 8'h00, 1'b0);

    // Fairness skip: 5 first, then 1 (searching from 6 wraps past 7 and 0)
    b15.req = 8'b0010_0010;
    tick(); c15("fair_idx5_a", 3'd5, 8'h20, 1'b1);
    tick(); c15("fair_idx5_b", 3'd5, 8'h20, 1'b1);
    b15.req = 8'b0000_0010;
    tick(); c15("fair_gap", 3'd5, 8'h00, 1'b0);
    b15.req = 8'b0010_0010;
    tick(); c15("fair_idx1", 3'd1, 8'h02, 1'b1);
    b15.req = 8'h00;
    tick(); c15("fair_release", 3'd1, 8'h00, 1'b0);

    // Reset while 6 owns the grant (pointer 2 would otherwise pick 6 again)
    b15.req = 8'b0100_0010;
    tick(); c15("busy_idx6", 3'd6, 8'h40, 1'b1);
    rst15 = 1'b1;
    tick(); c15("midreset_clear", 3'd0, 8'h00, 1'b0);
    rst15 = 1'b0;
    tick(); c15("post_reset_lowest", 3'd1, 8'h02, 1'b1);
    b15.req = 8'h00;

    // Saturated rotation with hold limit 3, including the 7->0 wrap
    rst3 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        c3($sformatf("rot_own%0d_c%0d", k, c), 3'(k % 8), 8'h01 << (k % 8), 1'b1);
      end
      tick(); c3($sformatf("rot_gap%0d", k), 3'(k % 8), 8'h00, 1'b0);
    end
    b3.req = 8'h00;

    // Early release under hold limit 2, then a full forced hold of requester 4
    rst2 = 1'b0;
    tick(); c2("mh2_reset_idle", 3'd0, 8'h00, 1'b0);
    b2.req = 8'b0000_1000;
    tick(); c2("mh2_grant3", 3'd3, 8'h08, 1'b1);
    b2.req = 8'b0001_0000;
    tick(); c2("mh2_early_release", 3'd3, 8'h00, 1'b0);
    tick(); c2("mh2_grant4_a", 3'd4, 8'h10, 1'b1);
    tick(); c2("mh2_grant4_b", 3'd4, 8'h10, 1'b1);
    tick(); c2("mh2_forced_release", 3'd4, 8'h00, 1'b0);
    b2.req = 8'h00;
    tick(); c2("mh2_idle", 3'd4, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
# rr_arb8

Eight-way round-robin arbiter that shares a single 3-to-8 decoder-selected resource among eight requesters. It picks one requester at a time, drives the 3-bit select index that feeds the decoder, and presents the matching one-hot grant. A grant is held until the owner drops its request or a configurable hold limit expires, whichever comes first. It sits between the requesting blocks and the decoder/resource it controls.

## Interface
- MAXHOLD, 15: maximum consecutive cycles one requester may hold the grant. Legal range is 1..15; the hold counter is 4 bits.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- REQ  in  8  request vector; REQ[i] high means requester i wants the resource.
- GIDX  out  3  index of the current owner, routed to the decoder select inputs.
- GNT  out  8  one-hot grant, active-high. GNT[i] = VALID & (GIDX == i). All zero when VALID = 0.
- VALID  out  1  a grant is active this cycle.

## Operation
- States: IDLE and BUSY. All outputs are registered.
- Internal registers:
  - PTR, 3 bits: the priority start point.
  - HCNT, 4 bits: the hold counter.
- Reset (RST sampled high at an edge), applied on that edge: state = IDLE, GIDX = 0, VALID = 0, GNT = 0, PTR = 0, HCNT = 0. Reset overrides every other event, including during BUSY.
- IDLE, no REQ bit set: remain in IDLE. VALID = 0.
- IDLE, any REQ bit set:
  - Search indices PTR, PTR+1, … PTR+7, all mod 8; the first set bit wins.
  - Load GIDX = winner, VALID = 1, HCNT = 1, and go to BUSY.
- BUSY, each edge, conditions checked in this order:
  1. REQ[GIDX] == 0 (voluntary release): go to IDLE, VALID = 0, PTR = GIDX+1 mod 8.
  2. HCNT == MAXHOLD (forced release): go to IDLE, VALID = 0, PTR = GIDX+1 mod 8.
  3. Otherwise: stay in BUSY and increment HCNT.
- GIDX keeps its last value in IDLE; only GNT and VALID are cleared.
- Changes on other REQ bits during BUSY have no effect until the next IDLE.
- A requester whose grant was forcibly removed while still requesting becomes lowest priority. It is re-granted only after every other active requester has had a turn.
- Wrap-around: when GIDX = 7, PTR becomes 0.

## Timing
- Grant latency: REQ rising before edge n (seen in IDLE) gives GNT/VALID high after edge n. That is 1 cycle.
- Release latency: REQ[GIDX] falling before edge m clears GNT after edge m.
- Mandatory gap: every grant is followed by at least one IDLE cycle with GNT = 0. Back-to-back ownership changes are therefore separated by exactly 1 idle cycle when requests are pending.
- Maximum continuous grant is MAXHOLD cycles. With MAXHOLD = 1 and all eight requesting, the pattern is grant, gap, grant, gap, with the owner rotating 0,1,2,…,7,0.
- GNT is never multi-hot. GNT and VALID never change except on a CLK edge.

## Test plan
- Reset: hold RST high for 2 cycles with REQ = 8'hFF. Required: GNT = 0, VALID = 0, GIDX = 0 throughout. After release, the first grant goes to index 0 one cycle later.
- Single requester: REQ = 8'b00000100 held for 5 cycles, then dropped. Required:
  - GIDX = 2 and GNT = 8'b00000100 one cycle after assertion.
  - With MAXHOLD = 15, the grant stays for 5 cycles.
  - GNT = 0 one cycle after the drop.
- Rotation under saturation: MAXHOLD = 3, REQ = 8'hFF held. Required:
  - Grants go to 0,1,…,7,0 in order.
  - Each grant lasts exactly 3 cycles, followed by 1 IDLE cycle.
  - The wrap from 7 to 0 is included.
- Fairness skip: with PTR = 5 after a release, present REQ = 8'b00100010. Required: the grant goes to index 5 first, then index 1, and index 5 does not repeat before index 1.
- Reset mid-operation: while GIDX = 6 is BUSY, assert RST for 1 cycle with REQ held. Required:
  - Outputs clear on that edge.
  - PTR returns to 0, so the next grant goes to the lowest set REQ bit.
- Early release vs limit: MAXHOLD = 2. Requester 3 drops REQ after 1 cycle. Required: release is at 1 cycle, with no forced-release behaviour, and the next requester is granted after exactly 1 gap cycle.
